// File: rtl/cw_bus_arbiter_pkg.sv
// Shared types for the CW bus arbiter: FSM state encoding and bus width default.
package cw_arb_pkg;

  localparam int CW_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } st_t;

endpackage

// File: rtl/cw_bus_arbiter_if.sv
// External CW bus port: muxed io plus req/dir/ack/err handshake.
interface cw_bus_arbiter_if #(
  parameter int CW_W = cw_arb_pkg::CW_W_DEF
);
  logic            cw_req;
  logic            cw_dir;
  logic [CW_W-1:0] cw_io_o;
  logic [CW_W-1:0] cw_io_i;
  logic            cw_ack;
  logic            cw_err;

  modport master (output cw_req, cw_dir, cw_io_o, input cw_io_i, cw_ack, cw_err);
  modport slave  (input cw_req, cw_dir, cw_io_o, output cw_io_i, cw_ack, cw_err);
endinterface

// File: rtl/cw_bus_arbiter_rr_grant.sv
// Combinational round-robin picker: first set request at or above rr_ptr, wrapping mod NREQ.
module cw_rr_grant #(
  parameter int NREQ = 2,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_ptr,
  output logic [IW-1:0]   gnt_idx,
  output logic            gnt_vld
);
  int idx;

  // Walk offsets from farthest to nearest so the nearest set bit is written last.
  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = (int'(rr_ptr) + i) % NREQ;
      if (req[idx]) begin
        gnt_idx = IW'(idx);
        gnt_vld = 1'b1;
      end
    end
  end
endmodule

// File: rtl/cw_bus_arbiter.sv
// Round-robin arbiter sequencing ADDR/DATA/RESP on the CW external bus for NREQ requesters.
// Optional data-phase abort counter enabled by defining CW_ARB_TIMEOUT_EN.
module cw_bus_arbiter
  import cw_arb_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int CW_W   = CW_W_DEF,
  parameter int TO_CYC = 255
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [NREQ-1:0]            req_i,
  input  logic [NREQ-1:0]            we_i,
  input  logic [NREQ-1:0][CW_W-1:0]  adr_i,
  input  logic [NREQ-1:0][CW_W-1:0]  dat_i,
  output logic [NREQ-1:0]            ack_o,
  output logic [NREQ-1:0]            err_o,
  output logic [CW_W-1:0]            dat_o,
  output logic                       busy_o,
  cw_bus_arbiter_if.master           cw
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 4 || TO_CYC < 1) begin : g_bad_cfg
    $error("cw_bus_arbiter: NREQ must be 2..4 and TO_CYC >= 1");
  end

  st_t             st;
  logic [IW-1:0]   rr_ptr, g, gnt_idx;
  logic            gnt_vld;
  logic            we_q;
  logic [CW_W-1:0] dat_q;

`ifdef CW_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TO_CYC + 1);
  logic [TW-1:0] to_cnt;
`endif

  cw_rr_grant #(.NREQ(NREQ), .IW(IW)) u_rr (
    .req     (req_i),
    .rr_ptr  (rr_ptr),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      st         <= IDLE;
      rr_ptr     <= '0;
      g          <= '0;
      we_q       <= 1'b0;
      dat_q      <= '0;
      ack_o      <= '0;
      err_o      <= '0;
      dat_o      <= '0;
      busy_o     <= 1'b0;
      cw.cw_req  <= 1'b0;
      cw.cw_dir  <= 1'b0;
      cw.cw_io_o <= '0;
`ifdef CW_ARB_TIMEOUT_EN
      to_cnt     <= '0;
`endif
    end else begin
      ack_o <= '0;
      err_o <= '0;
      case (st)
        IDLE: if (gnt_vld) begin
          g          <= gnt_idx;
          we_q       <= we_i[gnt_idx];
          dat_q      <= dat_i[gnt_idx];
          st         <= ADDR;
          busy_o     <= 1'b1;
          cw.cw_req  <= 1'b1;
          cw.cw_dir  <= 1'b1;
          cw.cw_io_o <= adr_i[gnt_idx];
        end
        ADDR: begin
          st         <= DATA;
          cw.cw_dir  <= we_q;
          cw.cw_io_o <= we_q ? dat_q : '0;
`ifdef CW_ARB_TIMEOUT_EN
          to_cnt     <= '0;
`endif
        end
        DATA: begin
          if (cw.cw_ack || cw.cw_err) begin
            st         <= RESP;
            cw.cw_req  <= 1'b0;
            cw.cw_dir  <= 1'b0;
            cw.cw_io_o <= '0;
            // err wins when the slave raises both
            if (cw.cw_err) err_o[g] <= 1'b1;
            else begin
              ack_o[g] <= 1'b1;
              if (!we_q) dat_o <= cw.cw_io_i;
            end
          end
`ifdef CW_ARB_TIMEOUT_EN
          // to_cnt holds DATA cycles already elapsed; this cycle brings it to TO_CYC
          else if (to_cnt == TW'(TO_CYC - 1)) begin
            st         <= RESP;
            cw.cw_req  <= 1'b0;
            cw.cw_dir  <= 1'b0;
            cw.cw_io_o <= '0;
            err_o[g]   <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          st     <= IDLE;
          busy_o <= 1'b0;
          rr_ptr <= (g == IW'(NREQ - 1)) ? '0 : g + 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cw_bus_arbiter.sv
// Directed bench for cw_bus_arbiter: reset, read, round-robin, write with err, timeout, mid-transfer reset.
module tb_cw_bus_arbiter;
  localparam int NREQ = 2;
  localparam int CW_W = 16;
`ifdef CW_ARB_TIMEOUT_EN
  localparam int TO_CYC = 4;
`else
  localparam int TO_CYC = 255;
`endif

  logic                      i_clk = 1'b0;
  logic                      i_rst;
  logic [NREQ-1:0]           req_i, we_i, ack_o, err_o;
  logic [NREQ-1:0][CW_W-1:0] adr_i, dat_i;
  logic [CW_W-1:0]           dat_o;
  logic                      busy_o;
  int                        n_chk = 0;
  int                        n_err = 0;

  cw_bus_arbiter_if #(.CW_W(CW_W)) cw_if ();

  cw_bus_arbiter #(.NREQ(NREQ), .CW_W(CW_W), .TO_CYC(TO_CYC)) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .req_i  (req_i),
    .we_i   (we_i),
    .adr_i  (adr_i),
    .dat_i  (dat_i),
    .ack_o  (ack_o),
    .err_o  (err_o),
    .dat_o  (dat_o),
    .busy_o (busy_o),
    .cw     (cw_if.master)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // advance one cycle; outputs are observed and inputs driven 1ns after the edge
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    i_rst = 1'b1;
    req_i = 2'b11;
    we_i  = '0;
    adr_i = '0;
    dat_i = '0;
    cw_if.cw_io_i = '0;
    cw_if.cw_ack  = 1'b0;
    cw_if.cw_err  = 1'b0;

    // reset with both requesting
    tick(); tick();
    chk("rst_cw_req", 32'(cw_if.cw_req), 32'd0);
    chk("rst_ack",    32'(ack_o),        32'd0);
    chk("rst_busy",   32'(busy_o),       32'd0);
    chk("rst_err",    32'(err_o),        32'd0);
    i_rst = 1'b0;
    req_i = 2'b01;
    adr_i[0] = 16'h1234;

    // single read from r0
    tick();
    chk("rd_addr_io",  32'(cw_if.cw_io_o), 32'h1234);
    chk("rd_addr_dir", 32'(cw_if.cw_dir),  32'd1);
    chk("rd_addr_req", 32'(cw_if.cw_req),  32'd1);
    chk("rd_busy",     32'(busy_o),        32'd1);
    tick();
    chk("rd_data_dir", 32'(cw_if.cw_dir),  32'd0);
    chk("rd_data_io",  32'(cw_if.cw_io_o), 32'h0);
    cw_if.cw_ack  = 1'b1;
    cw_if.cw_io_i = 16'hBEEF;
    tick();
    chk("rd_ack",      32'(ack_o),         32'h1);
    chk("rd_err",      32'(err_o),         32'h0);
    chk("rd_dat",      32'(dat_o),         32'hBEEF);
    chk("rd_resp_req", 32'(cw_if.cw_req),  32'd0);
    req_i = '0;
    cw_if.cw_ack = 1'b0;
    tick();
    chk("rd_idle_busy", 32'(busy_o), 32'd0);
    chk("rd_ack_pulse", 32'(ack_o),  32'h0);

    // both request continuously; rr_ptr is 1 after r0, so r1 goes first
    req_i    = 2'b11;
    adr_i[0] = 16'h1000;
    adr_i[1] = 16'h2000;
    cw_if.cw_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cw_if.cw_io_i = 16'h5000 + 16'(k);
      tick();
      chk("rr_adr", 32'(cw_if.cw_io_o), (k % 2 == 0) ? 32'h2000 : 32'h1000);
      tick();
      tick();
      chk("rr_ack", 32'(ack_o), (k % 2 == 0) ? 32'h2 : 32'h1);
      chk("rr_dat", 32'(dat_o), 32'h5000 + 32'(k));
      tick();
    end
    req_i = '0;
    cw_if.cw_ack = 1'b0;

    // write from r1, slave stalls then answers ack+err together
    req_i    = 2'b10;
    we_i     = 2'b10;
    adr_i[1] = 16'h0042;
    dat_i[1] = 16'hA5A5;
    tick();
    chk("wr_addr_io", 32'(cw_if.cw_io_o), 32'h0042);
    we_i     = '0;
    dat_i[1] = 16'h0000;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("wr_stall_dir", 32'(cw_if.cw_dir),  32'd1);
      chk("wr_stall_io",  32'(cw_if.cw_io_o), 32'hA5A5);
      chk("wr_stall_rsp", 32'({ack_o, err_o}), 32'h0);
      tick();
    end
    chk("wr_dir_last", 32'(cw_if.cw_dir), 32'd1);
    cw_if.cw_ack  = 1'b1;
    cw_if.cw_err  = 1'b1;
    cw_if.cw_io_i = 16'h1111;
    tick();
    chk("wr_err",   32'(err_o),        32'h2);
    chk("wr_noack", 32'(ack_o),        32'h0);
    chk("wr_dat",   32'(dat_o),        32'h5003);
    chk("wr_req",   32'(cw_if.cw_req), 32'd0);
    req_i = '0;
    cw_if.cw_ack = 1'b0;
    cw_if.cw_err = 1'b0;
    tick();

`ifdef CW_ARB_TIMEOUT_EN
    // rr_ptr is 0: r0 granted, slave silent, r1 queued behind it
    req_i    = 2'b11;
    adr_i[0] = 16'h00A0;
    adr_i[1] = 16'h00B0;
    tick();
    chk("to_adr0", 32'(cw_if.cw_io_o), 32'h00A0);
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("to_wait_err", 32'(err_o), 32'h0);
    end
    tick();
    chk("to_err", 32'(err_o),        32'h1);
    chk("to_req", 32'(cw_if.cw_req), 32'd0);
    req_i = 2'b10;
    tick();
    tick();
    chk("to_next_adr", 32'(cw_if.cw_io_o), 32'h00B0);
    tick();
    cw_if.cw_ack = 1'b1;
    tick();
    chk("to_next_ack", 32'(ack_o), 32'h2);
    req_i = '0;
    cw_if.cw_ack = 1'b0;
    tick();
`endif

    // reset in the middle of a DATA phase
    req_i    = 2'b01;
    we_i     = '0;
    adr_i[0] = 16'h0077;
    tick();
    tick();
    chk("mr_busy_data", 32'(busy_o), 32'd1);
    i_rst = 1'b1;
    cw_if.cw_ack = 1'b1;
    tick();
    chk("mr_req",  32'(cw_if.cw_req),   32'd0);
    chk("mr_busy", 32'(busy_o),         32'd0);
    chk("mr_rsp",  32'({ack_o, err_o}), 32'h0);
    i_rst = 1'b0;
    cw_if.cw_ack = 1'b0;
    tick();
    chk("mr_restart_req", 32'(cw_if.cw_req),  32'd1);
    chk("mr_restart_dir", 32'(cw_if.cw_dir),  32'd1);
    chk("mr_restart_io",  32'(cw_if.cw_io_o), 32'h0077);
    tick();
    cw_if.cw_ack  = 1'b1;
    cw_if.cw_io_i = 16'hC0DE;
    tick();
    chk("mr_ack", 32'(ack_o), 32'h1);
    chk("mr_dat", 32'(dat_o), 32'hC0DE);
    req_i = '0;
    cw_if.cw_ack = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
